pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard, forwarding and stall/flush controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB). It is the successor to the current pipeline, which runs uncontrolled. It drives per-stage enable/flush for the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC. It generates ALU operand forwarding selects and resolves load-use and RAW hazards. It handles branch flush, with branches resolved from EX_MEM. It freezes the pipeline on a data-memory ready handshake, with timeout detection and saturating performance counters.

Parameters:
AW, 5, register address width
FWD_EN, 1, 1 = forwarding from MEM/WB; 0 = resolve every RAW hazard by stalling
RF_BYPASS, 1, 1 = register file is write-before-read; 0 = also stall on WB-stage RAW when FWD_EN=0
TIMEOUT, 64, maximum consecutive memory wait cycles before error (≥2)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs1, id_rs2  in  AW  source registers of the instruction in ID
id_use1, id_use2  in  1  instruction in ID reads rs1 / rs2
ex_rs1, ex_rs2  in  AW  source registers in EX (ID_EX)
ex_rd  in  AW  destination register in EX
ex_regwrite, ex_memread  in  1  EX control bits
mem_rd  in  AW  destination register in MEM (EX_MEM)
mem_regwrite  in  1  MEM control bit
wb_rd  in  AW  destination register in WB (MEM_WB)
wb_regwrite  in  1  WB control bit
br_taken  in  1  EX_MEM_Branch & EX_MEM_Zero
mem_req, mem_ready  in  1  data-memory access request / completion
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1  synchronous bubble insert (load zeros)
fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 10 EX_MEM alu_out, 01 WB write_data
mem_err  out  1  sticky memory timeout flag
stall_cnt, flush_cnt  out  CNT_W  saturating counters

Behaviour:
- While rst=0 the following hold:
  - all enables, flushes and fwd_* = 0
  - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=flush_cnt=0
- Register x0 never creates a hazard or forward. Any comparison with rd=0 is false.
- Hazard matches:
  - match_ex = ex_regwrite & ex_rd≠0 & ((id_use1 & ex_rd==id_rs1) | (id_use2 & ex_rd==id_rs2))
  - match_mem and match_wb are defined the same way on the mem_* and wb_* signals.
- Priority, highest first, evaluated combinationally each cycle:
  1. freeze = (mem_req & ~mem_ready) | state==MERR
     - all five enables = 0, all flushes = 0
  2. br_taken
     - all enables = 1
     - if_id_flush = id_ex_flush = ex_mem_flush = 1; three wrong-path instructions are squashed
     - a coincident load-use is discarded
  3. load-use stall = ex_memread & match_ex
     - FWD_EN=0 extends the stall condition to match_ex | match_mem | (match_wb & ~RF_BYPASS)
     - pc_en = if_id_en = 0, id_ex_flush = 1, remaining enables = 1
  4. otherwise all enables = 1, no flush.
- Forwarding (FWD_EN=1; otherwise fwd_* = 00):
  - fwd_a = 10 if mem_regwrite & mem_rd≠0 & mem_rd==ex_rs1
  - else fwd_a = 01 if the same condition holds on wb_*
  - else fwd_a = 00
  - fwd_b is the same on ex_rs2. MEM beats WB when both match.
- Memory FSM (registered):
  - RUN→MWAIT when mem_req & ~mem_ready; wait_cnt ← 1.
  - In MWAIT:
    - mem_ready=1 → RUN, wait_cnt←0. Freeze releases in that same cycle (combinational), so the pipeline advances on that edge.
    - else wait_cnt++. When wait_cnt==TIMEOUT-1 with ready still low → MERR.
  - MERR: mem_err=1 and pipeline frozen until reset.
  - mem_req dropping while in MWAIT → RUN.
- A br_taken held during freeze is applied on the first unfrozen cycle. It is counted once.
- stall_cnt increments every cycle pc_en=0 while rst=1 and state≠MERR. It saturates at 2^CNT_W-1.
- flush_cnt increments once per cycle in which the branch flush is applied. It saturates.
- Reset asserted mid-MWAIT or MERR returns to RUN immediately (asynchronously) and clears mem_err and both counters.

Test Plan:
1. Load-use: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs1=5, id_use1=1 → pc_en=if_id_en=0, id_ex_flush=1 for exactly 1 cycle; stall_cnt 0→1. Repeat with ex_rd=0 → no stall.
2. Forwarding: mem_rd=wb_rd=7, both regwrite=1, ex_rs1=7, ex_rs2=7 → fwd_a=fwd_b=10. Then mem_regwrite=0 → fwd_a=fwd_b=01. With FWD_EN=0: fwd=00, and id_rs1=7 with mem match → stall.
3. Branch with simultaneous load-use: br_taken=1 together with the load-use of test 1 → all enables=1, three flushes=1, no stall, flush_cnt=1.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → enables=0 for 3 cycles, released in the ready cycle, stall_cnt=3. A br_taken asserted during the wait flushes only after release.
5. Timeout: TIMEOUT=4, mem_ready held 0 → MERR entered on the 4th cycle, mem_err=1, freeze persists. Assert rst=0 asynchronously mid-cycle → mem_err=0, counters=0, enables=0 while in reset.
6. Saturation: CNT_W=4, hold a stall for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding controller for a 5-stage pipeline with memory-wait freeze
module pipe_hazard_ctrl #(
  parameter int AW        = 5,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [AW-1:0]    ex_rs1,
  input  logic [AW-1:0]    ex_rs2,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_regwrite,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {RUN, MWAIT, MERR} state_t;
  state_t r_state, w_state_nxt;
  logic [WW-1:0] r_wait_cnt, w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic w_match_ex, w_match_mem, w_match_wb, w_freeze, w_stall;

  function automatic logic hit(input logic we, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                               input logic u1, input logic [AW-1:0] rs2, input logic u2);
    return we && rd != '0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction

  assign w_match_ex  = hit(ex_regwrite, ex_rd, id_rs1, id_use1, id_rs2, id_use2);
  assign w_match_mem = hit(mem_regwrite, mem_rd, id_rs1, id_use1, id_rs2, id_use2);
  assign w_match_wb  = hit(wb_regwrite, wb_rd, id_rs1, id_use1, id_rs2, id_use2);
  assign w_freeze    = (mem_req && !mem_ready) || r_state == MERR;
  assign w_stall     = (ex_memread && w_match_ex) ||
                       (FWD_EN == 0 && (w_match_ex || w_match_mem || (w_match_wb && RF_BYPASS == 0)));
  assign mem_err     = r_state == MERR;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  assign fwd_a = !(FWD_EN != 0 && rst) ? 2'b00 :
                 (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1) ? 2'b10 :
                 (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
  assign fwd_b = !(FWD_EN != 0 && rst) ? 2'b00 :
                 (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2) ? 2'b10 :
                 (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;

  // stage enables and bubbles: freeze beats branch flush beats hazard stall
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b000;
    if (rst && !w_freeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      if (br_taken) begin
        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
      end else if (w_stall) begin
        pc_en = 1'b0;
        if_id_en = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // memory wait tracking with timeout into a sticky error state
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt = r_wait_cnt;
    case (r_state)
      RUN: if (mem_req && !mem_ready) begin
        w_state_nxt = MWAIT;
        w_wait_nxt = WW'(1);
      end
      MWAIT: if (!mem_req || mem_ready) begin
        w_state_nxt = RUN;
        w_wait_nxt = '0;
      end else if (r_wait_cnt == WW'(TIMEOUT - 1)) begin
        w_state_nxt = MERR;
      end else begin
        w_wait_nxt = r_wait_cnt + WW'(1);
      end
      default: w_state_nxt = MERR;
    endcase
  end

  // state register and saturating stall/flush counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_wait_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (!pc_en && r_state != MERR && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (if_id_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for the hazard controller (forwarding and stall-only variants)
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, br_taken, mem_req, mem_ready;
  logic pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0, if_id_flush0, id_ex_flush0, ex_mem_flush0, mem_err0;
  logic pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_err1;
  logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
  logic [3:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
  logic [20:0] w_obs0, w_obs1;

  typedef struct {string name; bit slow; logic [20:0] exp;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_STL = 8'b00111_010;
  localparam logic [7:0] C_FRZ = 8'b00000_000;
  localparam logic [7:0] C_BR  = 8'b11111_111;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_fast (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en0), .if_id_en(if_id_en0), .id_ex_en(id_ex_en0), .ex_mem_en(ex_mem_en0), .mem_wb_en(mem_wb_en0),
    .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0), .ex_mem_flush(ex_mem_flush0),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .mem_err(mem_err0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  pipe_hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(0), .TIMEOUT(4), .CNT_W(4)) dut_slow (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .id_ex_en(id_ex_en1), .ex_mem_en(ex_mem_en1), .mem_wb_en(mem_wb_en1),
    .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .ex_mem_flush(ex_mem_flush1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .mem_err(mem_err1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  assign w_obs0 = {pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0, if_id_flush0, id_ex_flush0,
                   ex_mem_flush0, fwd_a0, fwd_b0, mem_err0, stall_cnt0, flush_cnt0};
  assign w_obs1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1, id_ex_flush1,
                   ex_mem_flush1, fwd_a1, fwd_b1, mem_err1, stall_cnt1, flush_cnt1};

  function automatic logic [20:0] mk(input logic [7:0] c, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic err, input logic [3:0] sc, input logic [3:0] fc);
    return {c, fa, fb, err, sc, fc};
  endfunction

  task automatic push(input string n, input bit s, input logic [20:0] x);
    exp_t e;
    e.name = n;
    e.slow = s;
    e.exp = x;
    q.push_back(e);
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, br_taken, mem_req, mem_ready} = '0;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
    ex_memread = 1'b1;
    ex_regwrite = 1'b1;
    ex_rd = rd;
    id_rs1 = a;
    id_use1 = ua;
    id_rs2 = b;
    id_use2 = ub;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [20:0] g;
    @(negedge clk);
    lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    {mem_regwrite, mem_rd, ex_rs1, ex_rs2, br_taken} = {1'b1, 5'd7, 5'd7, 5'd7, 1'b1};
    push("reset_fast", 0, '0);
    push("reset_slow", 1, '0);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      g = e.slow ? w_obs1 : w_obs0;
      n_chk++;
      if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [20:0] g;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); push("lu_stall", 0, mk(C_STL, 0, 0, 0, 0, 0)); end
        1: push("lu_release", 0, mk(C_RUN, 0, 0, 0, 1, 0));
        2: begin lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); push("lu_x0", 0, mk(C_RUN, 0, 0, 0, 1, 0)); end
        3: begin lu(5'd5, 5'd9, 1'b0, 5'd5, 1'b1); push("lu_rs2", 0, mk(C_STL, 0, 0, 0, 1, 0)); end
        default: push("lu_idle", 0, mk(C_RUN, 0, 0, 0, 2, 0));
      endcase
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        g = e.slow ? w_obs1 : w_obs0;
        n_chk++;
        if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_forward();
    exp_t e;
    logic [20:0] g;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle();
      {mem_rd, wb_rd, ex_rs1, ex_rs2, mem_regwrite, wb_regwrite} = {5'd7, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1};
      case (i)
        0: begin
          push("fwd_mem", 0, mk(C_RUN, 2'b10, 2'b10, 0, 0, 0));
          push("fwd_off", 1, mk(C_RUN, 0, 0, 0, 0, 0));
        end
        1: begin mem_regwrite = 1'b0; push("fwd_wb", 0, mk(C_RUN, 2'b01, 2'b01, 0, 0, 0)); end
        2: begin
          {id_rs1, id_use1} = {5'd7, 1'b1};
          push("fwd_nostall", 0, mk(C_RUN, 2'b10, 2'b10, 0, 0, 0));
          push("slow_mem_stall", 1, mk(C_STL, 0, 0, 0, 0, 0));
        end
        3: begin
          {id_rs1, id_use1, mem_regwrite} = {5'd7, 1'b1, 1'b0};
          push("fwd_wb_nostall", 0, mk(C_RUN, 2'b01, 2'b01, 0, 0, 0));
          push("slow_wb_stall", 1, mk(C_STL, 0, 0, 0, 1, 0));
        end
        4: begin
          {wb_rd, ex_rs2} = {5'd3, 5'd3};
          push("fwd_split", 0, mk(C_RUN, 2'b10, 2'b01, 0, 0, 0));
          push("slow_nouse", 1, mk(C_RUN, 0, 0, 0, 2, 0));
        end
        5: begin
          {mem_rd, wb_rd, ex_rs1, ex_rs2} = '0;
          {ex_regwrite, ex_rd, id_rs1, id_use1} = {1'b1, 5'd0, 5'd0, 1'b1};
          push("fwd_x0", 0, mk(C_RUN, 0, 0, 0, 0, 0));
          push("slow_x0", 1, mk(C_RUN, 0, 0, 0, 2, 0));
        end
        default: begin
          {mem_regwrite, wb_regwrite} = 2'b00;
          {ex_regwrite, ex_rd, id_rs1, id_use1} = {1'b1, 5'd9, 5'd9, 1'b1};
          push("fwd_ex_alu", 0, mk(C_RUN, 0, 0, 0, 0, 0));
          push("slow_ex_stall", 1, mk(C_STL, 0, 0, 0, 2, 0));
        end
      endcase
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        g = e.slow ? w_obs1 : w_obs0;
        n_chk++;
        if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic [20:0] g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      case (i)
        0: begin
          lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
          br_taken = 1'b1;
          push("br_over_lu", 0, mk(C_BR, 0, 0, 0, 0, 0));
          push("slow_br_over_lu", 1, mk(C_BR, 0, 0, 0, 0, 0));
        end
        1: push("br_count", 0, mk(C_RUN, 0, 0, 0, 0, 1));
        2: begin br_taken = 1'b1; push("br_again", 0, mk(C_BR, 0, 0, 0, 0, 1)); end
        default: push("br_count2", 0, mk(C_RUN, 0, 0, 0, 0, 2));
      endcase
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        g = e.slow ? w_obs1 : w_obs0;
        n_chk++;
        if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    logic [20:0] g;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 3) begin
        {mem_req, br_taken} = {1'b1, i >= 1};
        push("mw_freeze", 0, mk(C_FRZ, 0, 0, 0, 4'(i), 0));
      end else if (i == 3) begin
        {mem_req, mem_ready, br_taken} = 3'b111;
        push("mw_release_br", 0, mk(C_BR, 0, 0, 0, 3, 0));
      end else begin
        push("mw_after", 0, mk(C_RUN, 0, 0, 0, 3, 1));
      end
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        g = e.slow ? w_obs1 : w_obs0;
        n_chk++;
        if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [20:0] g;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 4) begin
        mem_req = 1'b1;
        push("to_wait", 0, mk(C_FRZ, 0, 0, 0, 4'(i), 0));
      end else if (i == 4) begin
        mem_req = 1'b1;
        push("to_merr", 0, mk(C_FRZ, 0, 0, 1, 4, 0));
      end else if (i < 7) begin
        {mem_ready, br_taken} = {1'b1, i == 6};
        push("to_sticky", 0, mk(C_FRZ, 0, 0, 1, 4, 0));
      end else if (i == 7) begin
        @(posedge clk);
        #2;
        mem_req = 1'b1;
        rst = 1'b0;
        push("to_async_rst", 0, '0);
      end else begin
        rst = 1'b1;
        push("to_after_rst", 0, mk(C_RUN, 0, 0, 0, 0, 0));
      end
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        g = e.slow ? w_obs1 : w_obs0;
        n_chk++;
        if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [20:0] g;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      idle();
      if (i < 20) begin
        lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        push("sat_stall", 0, mk(C_STL, 0, 0, 0, (i > 15) ? 4'd15 : 4'(i), 0));
      end else begin
        push("sat_hold", 0, mk(C_RUN, 0, 0, 0, 15, 0));
      end
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        g = e.slow ? w_obs1 : w_obs0;
        n_chk++;
        if (g !== e.exp) $display("FAIL %s: got %b want %b", e.name, g, e.exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
